// File: rtl/m_wb_uart.sv
// Wishbone classic 8N1 UART, runtime baud divisor; bus ACK one wait state after STB.
// No bus backpressure: TX writes while busy are dropped (txovr), unread RX bytes are overwritten (rxovr).
module m_wb_uart #(
  parameter int unsigned DIVISOR = 104
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        rxirq
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t   tx_state;
  rx_state_t   rx_state;
  logic [15:0] div, tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shift, rx_shift, rxbyte;
  logic        rx_s1, rxd;
  logic        rxvalid, rxovr, ferr, txovr;

  logic bus_hit, wr, rd, wr_data, rd_data, wr_stat;
  logic txbusy, tx_done, tx_load, tx_drop, rx_store, rx_ferr;
  logic unused_bits;

  assign bus_hit = CYC_I & STB_I & ~ACK_O;
  assign wr      = bus_hit & WE_I;
  assign rd      = bus_hit & ~WE_I;
  assign wr_data = wr & (ADR_I == 2'd0) & SEL_I[0];
  assign rd_data = rd & (ADR_I == 2'd0);
  assign wr_stat = wr & (ADR_I == 2'd1) & SEL_I[0];

  // A write landing on the stop bit's final cycle starts the next frame back to back.
  assign txbusy  = (tx_state != TX_IDLE);
  assign tx_done = (tx_state == TX_STOP) && (tx_cnt == 16'd0);
  assign tx_load = wr_data & (~txbusy | tx_done);
  assign tx_drop = wr_data & ~tx_load;

  assign rx_store = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && rxd;
  assign rx_ferr  = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && ~rxd;
  assign rxirq    = rxvalid;

  assign unused_bits = ^{DAT_I[31:16], SEL_I[3:2]};

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      usartTX  <= 1'b1;
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx_cnt   <= div - 16'd1;
      tx_bit   <= 3'd0;
      tx_shift <= DAT_I[7:0];
      usartTX  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: usartTX <= 1'b1;
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= div - 16'd1;
            usartTX  <= tx_shift[0];
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= div - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              usartTX  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              usartTX  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_STOP: begin
          if (tx_cnt == 16'd0) tx_state <= TX_IDLE;
          else tx_cnt <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rx_s1 <= 1'b1;
      rxd   <= 1'b1;
    end else begin
      rx_s1 <= usartRX;
      rxd   <= rx_s1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxd) begin
            rx_state <= RX_START;
            rx_cnt   <= div >> 1;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= rxd ? RX_IDLE : RX_DATA;
            rx_cnt   <= div - 16'd1;
            rx_bit   <= 3'd0;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rxd, rx_shift[7:1]};
            rx_cnt   <= div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) rx_state <= rxd ? RX_IDLE : RX_BREAK;
          else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_BREAK: if (rxd) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Flag updates: a new set always beats a same-edge clear.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_O   <= 1'b0;
      DAT_O   <= 32'd0;
      div     <= 16'(DIVISOR);
      rxbyte  <= 8'd0;
      rxvalid <= 1'b0;
      rxovr   <= 1'b0;
      ferr    <= 1'b0;
      txovr   <= 1'b0;
    end else begin
      ACK_O <= CYC_I & STB_I & ~ACK_O;
      if (rd) begin
        case (ADR_I)
          2'd0:    DAT_O <= {23'd0, rxvalid, rxbyte};
          2'd1:    DAT_O <= {27'd0, txovr, ferr, rxovr, rxvalid, txbusy};
          2'd2:    DAT_O <= {16'd0, div};
          default: DAT_O <= 32'd0;
        endcase
      end
      if (wr && ADR_I == 2'd2) begin
        if (SEL_I[0]) div[7:0]  <= DAT_I[7:0];
        if (SEL_I[1]) div[15:8] <= DAT_I[15:8];
      end
      if (rx_store) rxbyte <= rx_shift;
      rxvalid <= rx_store | (rxvalid & ~rd_data);
      rxovr   <= (rx_store & rxvalid & ~rd_data) | (rxovr & ~(wr_stat & DAT_I[2]));
      ferr    <= rx_ferr | (ferr & ~(wr_stat & DAT_I[3]));
      txovr   <= tx_drop | (txovr & ~(wr_stat & DAT_I[4]));
    end
  end

endmodule

// File: tb/tb_m_wb_uart.sv
// Bench for m_wb_uart: randomized UART frames and bus accesses checked against a frame-level model.
module tb_m_wb_uart;
  localparam int DIV0 = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] wdat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] rdat;
  logic        ack, tx, irq;
  logic        rx_line = 1'b1;

  int checks = 0, errors = 0;
  int cyc_cnt = 0;
  int cur_div = DIV0;
  bit mon_en = 1'b1;
  byte unsigned tx_exp[$], tx_got[$];
  bit m_rxvalid, m_rxovr, m_ferr, m_txovr;
  byte unsigned m_rxbyte;

  m_wb_uart #(.DIVISOR(DIV0)) dut (
    .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .DAT_O(rdat), .ACK_O(ack),
    .usartRX(rx_line), .usartTX(tx), .rxirq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q, output int waits);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    waits = 0;
    @(negedge clk);
    while (ack !== 1'b1 && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    if (ack !== 1'b1) chk("ack_timeout", {31'd0, ack}, 32'd1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    int w;
    bus(1'b0, a, 32'd0, 4'd0, q, w);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    int w;
    bus(1'b1, a, d, s, q, w);
  endtask

  task automatic chk_status(input string tag, input bit busy);
    logic [31:0] q;
    rd(2'd1, q);
    chk(tag, q, {27'd0, m_txovr, m_ferr, m_rxovr, m_rxvalid, busy});
  endtask

  task automatic rx_read_data();
    logic [31:0] q;
    rd(2'd0, q);
    chk("rx_data", q, {23'd0, m_rxvalid, m_rxbyte});
    m_rxvalid = 1'b0;
    chk("rx_irq_after_read", {31'd0, irq}, 32'd0);
  endtask

  // Drive one serial frame; the model is updated once the frame is over.
  task automatic send_frame(input byte unsigned b, input bit stop, input int low_extra);
    logic [9:0] f;
    f = frame_bits(b);
    f[9] = stop;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx_line = f[i];
      repeat (cur_div - 1) @(posedge clk);
    end
    repeat (low_extra) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (cur_div / 2 + 6) @(posedge clk);
    @(negedge clk);
    if (stop) begin
      if (m_rxvalid) m_rxovr = 1'b1;
      m_rxvalid = 1'b1;
      m_rxbyte = b;
    end else m_ferr = 1'b1;
  endtask

  task automatic tx_wait_idle(input int ld, output int diff);
    logic [31:0] q;
    int n;
    n = 0;
    q = 32'd1;
    while (q[0] && n < 400) begin
      rd(2'd1, q);
      n++;
    end
    if (q[0]) chk("tx_idle_timeout", q, 32'd0);
    diff = cyc_cnt - ld;
  endtask

  task automatic tx_probe(input int n, input bit exp_busy);
    byte unsigned b;
    int ld, diff;
    b = 8'($urandom);
    wr(2'd0, {24'd0, b}, 4'b0001);
    ld = cyc_cnt;
    tx_exp.push_back(b);
    repeat (n) @(negedge clk);
    chk_status("tx_busy_edge", exp_busy);
    tx_wait_idle(ld, diff);
  endtask

  // Frame-level receiver on usartTX, sampling mid-bit.
  initial begin : tx_monitor
    byte unsigned v;
    int d;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        d = cur_div;
        v = 8'd0;
        repeat (d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          v[i] = tx;
        end
        repeat (d) @(negedge clk);
        chk("tx_stop_bit", {31'd0, tx}, 32'd1);
        tx_got.push_back(v);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] q;
    logic [9:0]  f;
    int w, ld, diff, d, bad;
    byte unsigned b;

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    bus(1'b0, 2'd1, 32'd0, 4'd0, q, w);
    chk("rst_status", q, 32'd0);
    chk("ack_wait_states", w, 32'd1);
    rd(2'd2, q);  chk("rst_div", q, 32'd8);
    rd(2'd3, q);  chk("reserved_read", q, 32'd0);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
    @(negedge clk); chk("held_ack_c0", {31'd0, ack}, 32'd0);
    @(negedge clk); chk("held_ack_c1", {31'd0, ack}, 32'd1);
    @(negedge clk); chk("held_ack_c2", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;

    wr(2'd2, 32'hFFFF_0010, 4'b0001); rd(2'd2, q); chk("div_lo_write", q, 32'h10);
    wr(2'd2, 32'h0000_0300, 4'b0010); rd(2'd2, q); chk("div_hi_write", q, 32'h0310);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);    rd(2'd2, q); chk("reserved_write", q, 32'h0310);
    wr(2'd2, 32'd8, 4'b0011);         rd(2'd2, q); chk("div_restore", q, 32'd8);

    wr(2'd0, 32'h55, 4'b0001);
    tx_exp.push_back(8'h55);
    f = frame_bits(8'h55);
    bad = 0;
    for (int t = 0; t < 10 * DIV0; t++) begin
      if (tx !== f[t / DIV0]) bad++;
      @(negedge clk);
    end
    chk("tx_wave_bad_cycles", bad, 32'd0);
    chk_status("tx_done_status", 1'b0);

    tx_probe(10 * DIV0 - 2, 1'b1);
    tx_probe(10 * DIV0 - 1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(6, 16);
      wr(2'd2, d, 4'b0011);
      cur_div = d;
      rd(2'd2, q); chk("div_rand", q, d);
      b = 8'($urandom);
      wr(2'd0, {24'd0, b}, 4'b0001);
      ld = cyc_cnt;
      tx_exp.push_back(b);
      tx_wait_idle(ld, diff);
      chk("tx_busy_len", diff, 10 * d + 2);
    end

    b = 8'($urandom);
    wr(2'd0, {24'd0, b}, 4'b0001);
    tx_exp.push_back(b);
    ld = cyc_cnt;
    wr(2'd0, 32'hA5, 4'b0001);
    m_txovr = 1'b1;
    chk_status("txovr_set", 1'b1);
    wr(2'd1, 32'h10, 4'b0001);
    m_txovr = 1'b0;
    chk_status("txovr_clr", 1'b1);
    tx_wait_idle(ld, diff);
    chk_status("txovr_idle", 1'b0);

    chk("tx_frame_count", tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      chk("tx_byte", tx_got[i], tx_exp[i]);

    wr(2'd2, 32'd8, 4'b0011);
    cur_div = 8;

    send_frame(8'hA3, 1'b1, 0);
    chk("rx_irq_set", {31'd0, irq}, 32'd1);
    rx_read_data();
    rx_read_data();

    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    chk_status("rx_ovr_status", 1'b0);
    rx_read_data();
    wr(2'd1, 32'h04, 4'b0001);
    m_rxovr = 1'b0;
    chk_status("rxovr_clr", 1'b0);

    send_frame(8'($urandom), 1'b0, 40);
    chk_status("ferr_status", 1'b0);
    chk("ferr_irq", {31'd0, irq}, 32'd0);
    repeat (10) @(posedge clk);
    send_frame(8'h7E, 1'b1, 0);
    rx_read_data();
    wr(2'd1, 32'h08, 4'b0001);
    m_ferr = 1'b0;
    chk_status("ferr_clr", 1'b0);

    @(posedge clk); #1 rx_line = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (30) @(posedge clk);
    chk_status("glitch_status", 1'b0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      d = $urandom_range(6, 16);
      wr(2'd2, d, 4'b0011);
      cur_div = d;
      send_frame(8'($urandom), 1'b1, 0);
      chk("rx_irq_rand", {31'd0, irq}, {31'd0, m_rxvalid});
      if ($urandom_range(0, 1) == 1) rx_read_data();
      else chk_status("rx_status_rand", 1'b0);
    end

    mon_en = 1'b0;
    wr(2'd2, 32'd8, 4'b0011);
    cur_div = 8;
    wr(2'd0, 32'h00, 4'b0001);
    repeat (20) @(negedge clk);
    chk("midtx_line_low", {31'd0, tx}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
    m_rxvalid = 1'b0; m_rxovr = 1'b0; m_ferr = 1'b0; m_txovr = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_status("post_rst_status", 1'b0);
    rd(2'd2, q); chk("post_rst_div", q, 32'd8);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_wb_uart.md
Name: m_wb_uart

Overview:
- Wishbone B4 classic slave UART for midgetv on the iCE40UP5K boards.
- Replaces bit-banged usartTX/usartRX with hardware framing: 8N1, LSB first, runtime-programmable baud divisor.
- Sits downstream of m_midgetv_core on its STB_O/WE_O/ADR_O/DAT_O/SEL_O bus and drives ACK_I/DAT_I back to the core.
- Pins connect directly to the board UART pins.

Parameters:
- DIVISOR, 104, reset value of the baud divisor (clocks per bit; 12 MHz / 115200). Legal range 4..65535.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset, asynchronous, active-low
- CYC_I  in  1  Wishbone cycle
- STB_I  in  1  Wishbone strobe
- WE_I  in  1  write enable
- ADR_I  in  2  word address, bus bits [3:2]
- DAT_I  in  32  write data
- SEL_I  in  4  byte selects
- DAT_O  out  32  read data
- ACK_O  out  1  acknowledge
- usartRX  in  1  asynchronous serial input
- usartTX  out  1  serial output, idle high
- rxirq  out  1  high while rxvalid = 1

Behaviour:
- One clock: CLK_I; reset: RST_I, asynchronous, active-low.
- Reset values:
  - usartTX=1, ACK_O=0, DAT_O=0, rxirq=0.
  - All sticky flags 0; divisor=DIVISOR; TX and RX state machines IDLE.
  - RX synchroniser flops reset to 1.
- Bus handshake:
  - ACK_O <= CYC_I & STB_I & ~ACK_O. One wait state; a held strobe gives ACK_O for exactly one cycle, then 0.
  - Read data is registered into DAT_O on the edge that sets ACK_O. DAT_O holds its value otherwise.
  - Write side effects and read side effects occur on that same edge.
- Register map (ADR_I):
  - 00 DATA.
    - Read returns {23'h0, rxvalid, rxbyte} and clears rxvalid.
    - Write with SEL_I[0]: if txbusy=0, load DAT_I[7:0] and start TX; if txbusy=1, the byte is dropped and txovr=1.
  - 01 STATUS.
    - Read returns {27'h0, txovr, ferr, rxovr, rxvalid, txbusy}.
    - Write with SEL_I[0]: DAT_I[4:2] are write-one-to-clear for txovr/ferr/rxovr. Other bits are ignored.
  - 10 DIV.
    - Read returns {16'h0, div}.
    - Write updates div[7:0] with SEL_I[0] and div[15:8] with SEL_I[1]. Takes effect at the next bit boundary.
  - 11 reserved: reads 0, writes ignored.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - txbusy=1 from the load edge.
  - usartTX goes low on the next cycle.
  - Each bit lasts div cycles (down-counter reloaded with div-1).
  - txbusy clears at the end of the stop bit, 10*div cycles after the start bit begins.
  - A write on the cycle txbusy clears is accepted.
- RX path:
  - 2-FF synchroniser on usartRX; all RX logic uses the second stage.
  - IDLE: a low level enters START with counter = div/2 (truncated).
  - START at count 0: if the line is high (false start), go to IDLE. Otherwise go to DATA.
  - DATA: sample every div cycles, shifting in LSB first, 8 bits. Then STOP, sampled after div cycles.
  - STOP=1: rxbyte <= shifted byte and rxvalid=1. If rxvalid was already 1, rxovr=1 and the new byte overwrites.
  - STOP=0: ferr=1, byte discarded, go to BREAK. BREAK waits for the line high, then IDLE.
- Simultaneous events:
  - DATA read clearing rxvalid on the same edge as a new byte store: the store wins, rxvalid stays 1, no rxovr.
  - W1C on the same edge as a new set of the same flag: set wins.
- Reset mid-frame aborts both FSMs immediately; usartTX=1 asynchronously.
- The divisor counter is 16 bits. div<4 is illegal and behaviour is unspecified.

Test Plan:
- Reset, DIVISOR=8: usartTX=1, read STATUS -> 0, read DIV -> 0x0008, ACK_O single-cycle with one wait state.
- Write DATA 0x55, DIVISOR=8: usartTX pattern 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles. txbusy=1 for 80 cycles, then 0. Second write while busy -> STATUS bit4=1; W1C 0x10 clears it.
- Drive an RX frame 0xA3 at 8 cycles/bit: rxirq rises after the stop sample. DATA read -> 0x1A3, then rxirq=0; next DATA read -> 0x0A3.
- Two frames 0x11, 0x22 with no read between: STATUS -> rxovr=1, rxvalid=1; DATA read -> 0x122.
- Frame with stop bit 0, line held low 40 cycles: ferr=1, rxvalid=0. After the line returns high, a following frame 0x7E is received correctly.
- 3-cycle low glitch on usartRX: no state change. Reset asserted mid-TX: usartTX=1 immediately, txbusy=0 after release.
